// File: rtl/instruction_memory_arbiter.sv
// Shared single-read-port program memory serving NUM_PORTS fetch handshakes plus a host load port.
// Optional build macro INSTRUCTION_MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority.
module instruction_memory_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   memory_valid,
  input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic [NUM_PORTS-1:0]                   memory_ready,
  output logic [NUM_PORTS*MEMORY_WIDTH-1:0]      memory_data,
  input  logic                                   load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]           load_addr,
  input  logic [MEMORY_WIDTH-1:0]                load_data,
  output logic                                   load_ready
);

  localparam int DEPTH = 1 << MEMORY_ADDR_WIDTH;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [MEMORY_WIDTH-1:0]      mem [DEPTH];
  logic                         gnt_any;
  logic [IDX_W-1:0]             gnt_idx;
  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr;

`ifdef INSTRUCTION_MEMORY_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  // Scan upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!gnt_any && memory_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!reset || load_valid) gnt_any = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
`else
  // Descending scan so the lowest-indexed requester is the last assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (memory_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    if (!reset || load_valid) gnt_any = 1'b0;
  end
`endif

  always_comb begin
    memory_ready = '0;
    rd_addr      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx == IDX_W'(p)) begin
        memory_ready[p] = gnt_any;
        rd_addr         = memory_addr[p*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memory_data <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_any && gnt_idx == IDX_W'(p)) begin
          memory_data[p*MEMORY_WIDTH +: MEMORY_WIDTH] <= mem[rd_addr];
        end
      end
    end
  end

  // Program contents survive reset; only host writes outside reset land.
  always_ff @(posedge clk) begin
    if (reset && load_valid) begin
      mem[load_addr] <= load_data;
    end
  end

  assign load_ready = 1'b1;

endmodule

// File: doc/instruction_memory_arbiter.md
# instruction_memory_arbiter

- Shared instruction-memory responder for a cluster of `basic_block` engines.
- Serves each engine's fetch handshake (`memory_valid`/`memory_addr` in, `memory_ready`/`memory_data` out) from one internal single-read-port program memory.
- Accepts at most one fetch per cycle.
- Also exposes a host write port for loading the program before or between runs.

## Interface

Parameters:
- NUM_PORTS, 4, number of `basic_block` requesters (≥1).
- MEMORY_WIDTH, 16, instruction word width.
- MEMORY_ADDR_WIDTH, 11, address width; memory depth is 2**MEMORY_ADDR_WIDTH words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memory_valid  in  NUM_PORTS  per-port fetch request.
- memory_addr  in  NUM_PORTS*MEMORY_ADDR_WIDTH  per-port fetch address; port p is bits [p*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH].
- memory_ready  out  NUM_PORTS  per-port grant; combinational, at most one bit high.
- memory_data  out  NUM_PORTS*MEMORY_WIDTH  per-port registered instruction word; port p is bits [p*MEMORY_WIDTH +: MEMORY_WIDTH].
- load_valid  in  1  host write request.
- load_addr  in  MEMORY_ADDR_WIDTH  host write address.
- load_data  in  MEMORY_WIDTH  host write data.
- load_ready  out  1  constant 1; every host write is accepted in its cycle.

## Operation

- **Handshake:** a fetch on port p completes at the rising edge where `memory_valid[p] && memory_ready[p]`.
- **Grant rule:**
  - If `load_valid`=1, every `memory_ready` bit is 0 (host writes have priority).
  - Otherwise `memory_ready[p]`=1 for exactly one requesting port, chosen by the arbitration policy (see Configuration).
  - `memory_ready[p]` is never 1 while `memory_valid[p]`=0.
- **Read:** at the handshake edge, `mem[memory_addr[p]]` is captured into port p's data register.
  - The register holds that value until port p's next handshake.
  - Other ports' data registers are unchanged.
- **Write:** at any edge where `load_valid`=1, `mem[load_addr]` is written with `load_data`. A fetch of the same address granted in a later cycle returns the new word.
- **Arbitration pointer (round-robin build):**
  - `rr_ptr` is a register, range 0..NUM_PORTS-1.
  - The grant goes to the first requesting port at or after `rr_ptr`, searching upward and wrapping from NUM_PORTS-1 to 0.
  - On each handshake, `rr_ptr` becomes (granted index + 1) mod NUM_PORTS.
  - `rr_ptr` does not change in cycles with no handshake.
- **No request queueing:** a requester that is not granted keeps `memory_valid` high. The arbiter holds no state for it.
- **Memory contents** are not affected by reset.

## Timing

- Reset values: `memory_data` all 0, `rr_ptr`=0. While reset is low, `memory_ready` is all 0; `load_ready` is 1 and writes are ignored.
- Fetch latency: handshake at edge t; `memory_data[p]` is valid from just after edge t, so it is sampled correctly at edge t+1.
- Throughput: one fetch per cycle across all ports. A single port requesting continuously is granted every cycle when no other port requests and `load_valid`=0.
- A write and a fetch never share a cycle, so there is no same-cycle read/write collision.
- Reset asserted mid-operation:
  - `memory_ready` drops immediately (combinational from reset).
  - Data registers and `rr_ptr` clear asynchronously.
  - An in-flight handshake at that edge does not complete.
- When all `memory_valid` are 0, outputs hold and no register changes except memory writes.

## Configuration

- Macro: `INSTRUCTION_MEMORY_ARBITER_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration using `rr_ptr` as described in Operation.
- Undefined:
  - Fixed priority: the lowest-indexed requesting port always wins.
  - `rr_ptr` is not implemented.
  - A port may be starved by lower-indexed ports.
- All other behaviour is identical in both builds.

## Test plan

- **Load then fetch:** write mem[5]=16'hA0B1 via the load port; port 0 requests addr 5 → `memory_ready[0]`=1 in that cycle, and `memory_data[0]`=16'hA0B1 at the next edge.
- **Round-robin (macro defined):** ports 0–3 all hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each port's data matches its own address.
- **Fixed priority (macro undefined):** ports 0 and 2 hold valid → port 0 is granted every cycle and `memory_ready[2]` stays 0 until port 0 drops valid.
- **Load priority:** `load_valid`=1 for 3 cycles while port 1 requests → `memory_ready` is 0 for those 3 cycles and port 1 is granted on the 4th. A write to port 1's address during those cycles is visible in the data it receives.
- **Hold behaviour:** port 2 fetches addr 7 (value 16'h1234), then port 3 fetches addr 8 → `memory_data[2]` stays 16'h1234.
- **Reset mid-fetch:** drive reset low while port 0 is valid → `memory_ready`=0 and `memory_data` all 0. After release, the first grant goes to port 0 (`rr_ptr`=0).
